// File: rtl/pipe_pkg.sv
// Shared widths and stall-source counts for the in-order CPU pipeline stage registers.
package pipe_pkg;

    localparam int IF_ID_W   = 96;
    localparam int ID_EXE_W  = 214;
    localparam int EXE_MEM_W = 160;
    localparam int MEM_WB_W  = 104;

    localparam int IF_ID_STALL_N   = 1;
    localparam int ID_EXE_STALL_N  = 3;
    localparam int EXE_MEM_STALL_N = 2;
    localparam int MEM_WB_STALL_N  = 1;

    localparam int STALL_CNT_W = 16;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Upstream/downstream handshake bundle of one pipeline stage register.
// A beat moves when valid and allowin are both high at a rising edge; valid is
// never conditioned on allowin, while allowin may depend on downstream state.
interface pipe_stage_reg_if
    import pipe_pkg::*;
#(
    parameter int DATA_W = ID_EXE_W
);
    logic              in_valid;
    logic              in_allowin;
    logic [DATA_W-1:0] in_data;
    logic              out_allowin;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;

    modport master (
        output in_valid, in_data, out_allowin,
        input  in_allowin, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_allowin,
        output in_allowin, out_valid, out_data
    );
endinterface

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter with synchronous clear; stops at all-ones instead of wrapping.
module sat_counter
    import pipe_pkg::*;
#(
    parameter int W = STALL_CNT_W
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register with stall OR-ing, flush and a stall-cycle counter.
// Define PIPE_SKID_BUF_EN to add a second (skid) entry that registers in_allowin.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W  = ID_EXE_W,
    parameter int STALL_N = ID_EXE_STALL_N,
    parameter int CNT_W   = STALL_CNT_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic [STALL_N-1:0] stall,
    pipe_stage_reg_if.slave    bus,
    output logic               valid,
    output logic [CNT_W-1:0]   stall_cnt
);

    logic              ready_go;
    logic              in_fire;
    logic [DATA_W-1:0] m_data;

    assign ready_go      = ~|stall;
    assign bus.out_valid = valid & ready_go;
    assign bus.out_data  = m_data;
    assign in_fire       = bus.in_valid & bus.in_allowin;

`ifdef PIPE_SKID_BUF_EN
    logic              out_fire;
    logic              s_valid;
    logic [DATA_W-1:0] s_data;

    assign out_fire       = bus.out_valid & bus.out_allowin;
    // Depends only on a flop, so no combinational path from downstream or stall.
    assign bus.in_allowin = ~s_valid;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            valid   <= 1'b0;
            m_data  <= '0;
            s_valid <= 1'b0;
            s_data  <= '0;
        end else if (out_fire) begin
            s_valid <= 1'b0;
            if (s_valid) begin
                valid  <= 1'b1;
                m_data <= s_data;
            end else if (in_fire) begin
                valid  <= 1'b1;
                m_data <= bus.in_data;
            end else begin
                valid <= 1'b0;
            end
        end else if (in_fire) begin
            if (!valid) begin
                valid  <= 1'b1;
                m_data <= bus.in_data;
            end else begin
                s_valid <= 1'b1;
                s_data  <= bus.in_data;
            end
        end
    end
`else
    assign bus.in_allowin = ~valid | (ready_go & bus.out_allowin);

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            valid  <= 1'b0;
            m_data <= '0;
        end else begin
            if (bus.in_allowin) begin
                valid <= bus.in_valid;
            end
            if (in_fire) begin
                m_data <= bus.in_data;
            end
        end
    end
`endif

    // Flush freezes the counter for the cycle it is asserted.
    sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk(clk),
        .clr(reset),
        .inc(valid & ~ready_go & ~flush),
        .cnt(stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg; a second instance with a 4-bit counter
// shares the same stimulus to exercise counter saturation.
module tb_pipe_stage_reg;
    localparam int DW = 16;

    logic        clk;
    logic        reset;
    logic        flush;
    logic [2:0]  stall;
    logic        valid;
    logic [15:0] stall_cnt;
    logic        sat_valid;
    logic [3:0]  sat_cnt;

    int n_checks = 0;
    int n_errors = 0;

    logic [DW-1:0] exp_q[$];

    pipe_stage_reg_if #(.DATA_W(DW)) bus ();
    pipe_stage_reg_if #(.DATA_W(DW)) sat_bus ();

    assign sat_bus.in_valid    = bus.in_valid;
    assign sat_bus.in_data     = bus.in_data;
    assign sat_bus.out_allowin = bus.out_allowin;

    pipe_stage_reg #(.DATA_W(DW), .STALL_N(3), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .flush(flush), .stall(stall),
        .bus(bus), .valid(valid), .stall_cnt(stall_cnt)
    );

    pipe_stage_reg #(.DATA_W(DW), .STALL_N(3), .CNT_W(4)) dut_sat (
        .clk(clk), .reset(reset), .flush(flush), .stall(stall),
        .bus(sat_bus), .valid(sat_valid), .stall_cnt(sat_cnt)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] d, input logic oa, input logic [2:0] st);
        bus.in_valid    = v;
        bus.in_data     = d;
        bus.out_allowin = oa;
        stall           = st;
        #1;
    endtask

    initial begin
        int idx;
        int cyc;
        logic [DW-1:0] got;

        reset = 1'b1;
        flush = 1'b0;
        drive(1'b0, '0, 1'b1, 3'b000);
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data", 32'(bus.out_data), 32'd0);
        check("rst_cnt", 32'(stall_cnt), 32'd0);
        check("rst_allowin", 32'(bus.in_allowin), 32'd1);

        // stream 1..4, one beat per cycle
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, DW'(i), 1'b1, 3'b000);
            tick();
            check("stream_data", 32'(bus.out_data), 32'(i));
            check("stream_ov", 32'(bus.out_valid), 32'd1);
        end
        drive(1'b0, '0, 1'b1, 3'b000);
        tick();
        check("stream_drain", 32'(valid), 32'd0);
        check("stream_cnt", 32'(stall_cnt), 32'd0);

        // stall held for 3 cycles with a valid head
        drive(1'b1, 16'h00a5, 1'b1, 3'b000);
        tick();
`ifdef PIPE_SKID_BUF_EN
        drive(1'b0, 16'h00bb, 1'b1, 3'b010);
`else
        drive(1'b1, 16'h00bb, 1'b1, 3'b010);
        check("stall_allowin", 32'(bus.in_allowin), 32'd0);
`endif
        for (int i = 0; i < 3; i++) begin
            check("stall_ov", 32'(bus.out_valid), 32'd0);
            tick();
            check("stall_data", 32'(bus.out_data), 32'h00a5);
        end
        check("stall_cnt3", 32'(stall_cnt), 32'd3);
        drive(1'b0, '0, 1'b1, 3'b000);
        check("stall_release_ov", 32'(bus.out_valid), 32'd1);
        check("stall_release_data", 32'(bus.out_data), 32'h00a5);
        tick();
        check("stall_once", 32'(bus.out_valid), 32'd0);

        // backpressure: 0x77 waits until downstream accepts
        drive(1'b1, 16'h0033, 1'b1, 3'b000);
        tick();
        drive(1'b1, 16'h0077, 1'b0, 3'b000);
`ifndef PIPE_SKID_BUF_EN
        check("bp_allowin", 32'(bus.in_allowin), 32'd0);
`endif
        for (int i = 0; i < 2; i++) begin
            check("bp_ov", 32'(bus.out_valid), 32'd1);
            tick();
            check("bp_data", 32'(bus.out_data), 32'h0033);
        end
        drive(1'b1, 16'h0077, 1'b1, 3'b000);
        tick();
        check("bp_capture", 32'(bus.out_data), 32'h0077);
        drive(1'b0, '0, 1'b1, 3'b000);
        tick();
        check("bp_drain", 32'(valid), 32'd0);
        check("bp_cnt", 32'(stall_cnt), 32'd3);

        // flush kills the head and the same-cycle beat; counter frozen while stalled
        drive(1'b1, 16'h0011, 1'b1, 3'b000);
        tick();
        check("flush_pre", 32'(bus.out_data), 32'h0011);
        flush = 1'b1;
        drive(1'b1, 16'h0022, 1'b1, 3'b100);
        tick();
        flush = 1'b0;
        drive(1'b0, '0, 1'b1, 3'b000);
        check("flush_valid", 32'(valid), 32'd0);
        check("flush_data", 32'(bus.out_data), 32'd0);
        check("flush_cnt", 32'(stall_cnt), 32'd3);
        tick();
        check("flush_no22_valid", 32'(valid), 32'd0);
        check("flush_no22_data", 32'(bus.out_data), 32'd0);

        // stream 1..5 with one cycle of downstream backpressure; scoreboard order
        for (int i = 1; i <= 5; i++) exp_q.push_back(DW'(i));
        idx = 1;
        cyc = 0;
        while ((exp_q.size() != 0) && (cyc < 40)) begin
            drive(idx <= 5, DW'(idx), cyc != 2, 3'b000);
`ifdef PIPE_SKID_BUF_EN
            if (cyc == 3) check("skid_allowin_fall", 32'(bus.in_allowin), 32'd0);
`endif
            if (bus.out_valid && bus.out_allowin) begin
                got = bus.out_data;
                if (exp_q.size() != 0) check("sb_data", 32'(got), 32'(exp_q.pop_front()));
            end
            if (bus.in_valid && bus.in_allowin) idx++;
            tick();
            cyc++;
        end
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        drive(1'b0, '0, 1'b1, 3'b000);
        check("sb_no_dup", 32'(bus.out_valid), 32'd0);
        tick();
        check("sb_empty", 32'(valid), 32'd0);

        // saturation: 20 stalled cycles on top of the 3 already counted
        drive(1'b1, 16'h0055, 1'b1, 3'b000);
        tick();
        drive(1'b0, '0, 1'b1, 3'b001);
        for (int i = 0; i < 12; i++) tick();
        check("sat_reach", 32'(sat_cnt), 32'd15);
        check("wide_cnt15", 32'(stall_cnt), 32'd15);
        for (int i = 0; i < 8; i++) tick();
        check("sat_hold", 32'(sat_cnt), 32'd15);
        check("wide_cnt23", 32'(stall_cnt), 32'd23);
        check("sat_head_data", 32'(bus.out_data), 32'h0055);
        drive(1'b0, '0, 1'b1, 3'b000);
        tick();
        check("sat_drain", 32'(valid), 32'd0);

        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("rst2_cnt", 32'(stall_cnt), 32'd0);
        check("rst2_sat_cnt", 32'(sat_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised inter-stage pipeline register for the in-order CPU pipeline (IF/ID, ID/EXE, EXE/MEM, MEM/WB).
- Uses the valid/allowin handshake.
- Generalises the ID/EXE register:
  - configurable payload width;
  - N OR-ed stall sources (div, divu, axi, ...);
  - flush that also drops the incoming beat;
  - data capture gated correctly on in_allowin;
  - saturating stall-cycle counter for performance debug;
  - optional 2-entry skid buffer that breaks the combinational allowin chain.

Parameters:
- DATA_W, 214, payload width in bits.
- STALL_N, 3, number of independent stall (block) inputs.
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  kill stage contents and the incoming beat (exception/branch flush).
- stall  in  STALL_N  per-source block; any bit high holds the stage.
- in_valid  in  1  upstream beat valid.
- in_allowin  out  1  this stage accepts a beat this cycle.
- in_data  in  DATA_W  upstream payload.
- out_allowin  in  1  downstream accepts.
- out_valid  out  1  beat offered downstream.
- out_data  out  DATA_W  registered payload.
- valid  out  1  stage occupied (head entry).
- stall_cnt  out  CNT_W  cycles spent occupied but held by stall.

Behaviour:
- ready_go = ~|stall.
- in_fire = in_valid & in_allowin.
- out_fire = out_valid & out_allowin.
- Base mode (no skid):
  - in_allowin = !valid | (ready_go & out_allowin); combinational.
  - out_valid = valid & ready_go.
- Priority per edge: reset > flush > normal.
- reset: valid=0, out_data=0, stall_cnt=0, skid cleared.
- flush: valid=0, out_data=0, skid cleared, stall_cnt held. A beat presented the same cycle is discarded even if in_allowin=1.
- Normal operation:
  - When in_allowin: valid <= in_valid.
  - When in_fire: out_data <= in_data.
  - Otherwise out_data holds. Data is never loaded while the stage is held.
- Latency: 1 cycle from in_fire to out_valid (if ready_go).
- Throughput: 1 beat/cycle with no stalls.
- Stalls:
  - A stall with valid=1 holds valid and out_data, and forces out_valid=0 and in_allowin=0.
  - A stall with valid=0 does not block acceptance.
- out_allowin=0 with valid=1 holds the stage; out_valid stays asserted (unless stalled).
- Simultaneous out_fire and in_fire: the new beat replaces the old with no bubble.
- stall_cnt: +1 each cycle valid & !ready_go. Saturates at all-ones, with no wrap.

Optional Feature:
- Macro PIPE_SKID_BUF_EN.
- Defined:
  - Adds a skid entry S (s_valid, s_data) behind the head M.
  - in_allowin = !s_valid, registered, so there is no combinational path from out_allowin or stall.
  - On out_fire: M <= S if s_valid; else M <= input if in_fire; else M empty. S is cleared.
  - No out_fire and in_fire: M <= input if M empty; else S <= input.
  - Ordering is strictly FIFO; a beat is never lost or duplicated.
  - Flush and reset clear both entries.
  - Latency is unchanged (1 cycle); the second beat may wait in S.
- Undefined: base mode exactly; no S logic.

Decomposition:
- Shared package pipe_pkg: default widths (IF_ID_W, ID_EXE_W=214, EXE_MEM_W, MEM_WB_W) and STALL_N defaults per stage.
- The stall counter is a natural sub-module: sat_counter (parameter W; inc, clr inputs).
- Skid logic stays inline under the macro.

Test Plan:
- Stream: in_valid=1 with data 1,2,3,4, out_allowin=1, stall=0 -> out_data 1,2,3,4 on consecutive cycles after 1-cycle latency; stall_cnt=0.
- Stall: valid with data 0xA5, stall=3'b010 for 3 cycles -> out_valid=0, in_allowin=0, out_data holds 0xA5, stall_cnt=3; release -> 0xA5 delivered once.
- Backpressure: out_allowin=0 for 2 cycles with new in_data=0x77 presented -> out_data stays at the prior value, out_valid=1 throughout; 0x77 is captured only after release.
- Flush: stage holds 0x11, flush=1 and in_valid=1 with 0x22 in the same cycle -> next cycle valid=0, out_data=0, 0x22 never appears.
- Saturation (CNT_W=4): 20 stalled cycles -> stall_cnt=15, then held.
- Skid (PIPE_SKID_BUF_EN): out_allowin dropped for 1 cycle during stream 1..5 -> in_allowin falls the cycle after S fills; output is 1..5 in order, with no loss or duplicates.
